// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit / datapath pair: opcodes, flag
// bit positions and default widths.
package cpu_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 6;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_ADDC = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 2^AW x DW register file: two operand read ports plus a debug read port,
// one synchronous write port, entry 0 hardwired to zero.
module regfile_2r1w #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] raddr_d,
    output logic [DW-1:0] rdata_d
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
    assign rdata_d = (raddr_d == '0) ? '0 : mem[raddr_d];

endmodule

// File: rtl/datapath_unit.sv
// Execution end of the control-unit interface: operand read with one-deep
// writeback bypass, single-cycle ALU, and a shift-add multiplier that stalls issue.
module datapath_unit
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [AW-1:0] aa,
    input  logic [AW-1:0] ab,
    input  logic [AW-1:0] ad,
    input  logic          wr,
    input  logic [7:0]    inst,
    output logic [2:0]    flags,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    mul_state_t    state, state_nx;
    logic [DW-1:0] rf_a, rf_b, rf_d, op_a, op_b;
    logic [3:0]    opc;
    logic          accept, is_mul;
    logic [DW:0]   sum;
    logic [DW-1:0] res;
    logic          cout, upd, wen;
    logic [2:0]    fl_alu, fl_mul;
    logic [DW-1:0] m_cand, m_plier, m_acc, acc_nx;
    logic [CW-1:0] m_cnt;
    logic [AW-1:0] m_ad;
    logic          m_wr;

    regfile_2r1w #(.DW(DW), .AW(AW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_valid),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (aa),
        .rdata_a (rf_a),
        .raddr_b (ab),
        .rdata_b (rf_b),
        .raddr_d (dbg_addr),
        .rdata_d (rf_d)
    );

    // The WB entry is not yet in the register file; r0 is never forwarded.
    assign op_a     = (wb_valid && (wb_addr == aa) && (aa != '0)) ? wb_data : rf_a;
    assign op_b     = (wb_valid && (wb_addr == ab) && (ab != '0)) ? wb_data : rf_b;
    assign dbg_data = (wb_valid && (wb_addr == dbg_addr) && (dbg_addr != '0)) ? wb_data : rf_d;

    assign opc         = inst[7:4];
    assign issue_ready = (state == ST_IDLE);
    assign accept      = issue_valid && issue_ready;
    assign is_mul      = (opc == OP_MUL);

    always_comb begin
        sum  = '0;
        res  = '0;
        cout = 1'b0;
        upd  = 1'b1;
        wen  = wr;
        case (opc)
            OP_ADD:  begin sum = {1'b0, op_a} + {1'b0, op_b}; res = sum[DW-1:0]; cout = sum[DW]; end
            OP_ADDC: begin
                sum  = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, flags[FLAG_C]};
                res  = sum[DW-1:0];
                cout = sum[DW];
            end
            OP_SUB, OP_CMP: begin
                sum  = {1'b0, op_a} - {1'b0, op_b};
                res  = sum[DW-1:0];
                cout = sum[DW];
                wen  = wr && (opc == OP_SUB);
            end
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_SHL:  begin res = {op_a[DW-2:0], 1'b0}; cout = op_a[DW-1]; end
            OP_SHR:  begin res = {1'b0, op_a[DW-1:1]}; cout = op_a[0]; end
            OP_MOV:  res = op_a;
            OP_LDI:  res = {{(DW-4){1'b0}}, inst[3:0]};
            default: begin upd = 1'b0; wen = 1'b0; end
        endcase
        fl_alu         = '0;
        fl_alu[FLAG_N] = res[DW-1];
        fl_alu[FLAG_C] = cout;
        fl_alu[FLAG_Z] = (res == '0);
    end

    assign acc_nx = m_acc + (m_plier[0] ? m_cand : '0);

    always_comb begin
        fl_mul         = '0;
        fl_mul[FLAG_N] = acc_nx[DW-1];
        fl_mul[FLAG_Z] = (acc_nx == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_nx = ST_MUL;
            ST_MUL:  if (m_cnt == '0)      state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags    <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            m_cand   <= '0;
            m_plier  <= '0;
            m_acc    <= '0;
            m_cnt    <= '0;
            m_ad     <= '0;
            m_wr     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept && is_mul) begin
                    m_cand  <= op_a;
                    m_plier <= op_b;
                    m_acc   <= '0;
                    m_cnt   <= CNT_LAST;
                    m_ad    <= ad;
                    m_wr    <= wr;
                end else if (accept) begin
                    if (upd) flags <= fl_alu;
                    if (wen) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= ad;
                        wb_data  <= res;
                    end
                end
            end else begin
                m_acc   <= acc_nx;
                m_cand  <= {m_cand[DW-2:0], 1'b0};
                m_plier <= {1'b0, m_plier[DW-1:1]};
                m_cnt   <= m_cnt - 1'b1;
                if (m_cnt == '0) begin
                    flags <= fl_mul;
                    if (m_wr) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= m_ad;
                        wb_data  <= acc_nx;
                    end
                end
            end
        end
    end

endmodule
